// File: rtl/spi_mem_bridge_if.sv
// Byte-stream and SRAM bus bundle for spi_mem_bridge.
// master: bridge side; slave: SPI byte slave / arbiter / SRAM side.
interface spi_mem_bridge_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_load;
    logic [7:0]        tx_data;
    logic              bus_req;
    logic              bus_gnt;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_we_n;
    logic              mem_oe_n;
    logic              busy;

    modport master (
        input  rx_valid, rx_data, bus_gnt, mem_rdata,
        output tx_load, tx_data, bus_req, mem_addr, mem_wdata, mem_we_n, mem_oe_n, busy
    );

    modport slave (
        output rx_valid, rx_data, bus_gnt, mem_rdata,
        input  tx_load, tx_data, bus_req, mem_addr, mem_wdata, mem_we_n, mem_oe_n, busy
    );
endinterface

// File: rtl/spi_mem_bridge.sv
// SPI byte-command engine driving a shared SRAM bus: addressed bursts, bus acquire, sticky status.
// Optional SPI_MEM_CHECKSUM_EN adds an XOR checksum of written bytes, read back with command 0x07.
module spi_mem_bridge #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned WE_CYCLES   = 4,
    parameter int unsigned RD_CYCLES   = 2,
    parameter int unsigned GNT_TIMEOUT = 255
) (
    input  logic               clock_50,
    input  logic               reset,
    spi_mem_bridge_if.master   sif
);
    localparam int unsigned ADDR_BYTES = (ADDR_W + 7) / 8;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LEN, S_WDATA, S_WSTROBE, S_RDATA, S_RACCESS, S_ACQ_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        len_q, len_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              is_wr_q, is_wr_d;
    logic              disc_q, disc_d;
    logic [3:0]        status_q, status_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              tx_load_q, tx_load_d;
    logic              bus_req_q, bus_req_d;
    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;
    logic              busy_q;
    logic              owned;
`ifdef SPI_MEM_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    assign owned = bus_req_q & sif.bus_gnt;

    // Strobes are gated by ownership so a lost grant releases them within the same clock.
    assign sif.mem_we_n  = we_n_q | ~owned;
    assign sif.mem_oe_n  = oe_n_q | ~owned;
    assign sif.mem_addr  = addr_q;
    assign sif.mem_wdata = wdata_q;
    assign sif.tx_data   = tx_data_q;
    assign sif.tx_load   = tx_load_q;
    assign sif.bus_req   = bus_req_q;
    assign sif.busy      = busy_q;

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            is_wr_q   <= 1'b0;
            disc_q    <= 1'b0;
            status_q  <= '0;
            tx_data_q <= '0;
            wdata_q   <= '0;
            tx_load_q <= 1'b0;
            bus_req_q <= 1'b0;
            we_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            busy_q    <= 1'b0;
`ifdef SPI_MEM_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            is_wr_q   <= is_wr_d;
            disc_q    <= disc_d;
            status_q  <= status_d;
            tx_data_q <= tx_data_d;
            wdata_q   <= wdata_d;
            tx_load_q <= tx_load_d;
            bus_req_q <= bus_req_d;
            we_n_q    <= we_n_d;
            oe_n_q    <= oe_n_d;
            busy_q    <= (state_d != S_IDLE);
`ifdef SPI_MEM_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        is_wr_d   = is_wr_q;
        disc_d    = disc_q;
        status_d  = status_q;
        tx_data_d = tx_data_q;
        wdata_d   = wdata_q;
        tx_load_d = 1'b0;
        bus_req_d = bus_req_q;
        we_n_d    = we_n_q;
        oe_n_d    = oe_n_q;
`ifdef SPI_MEM_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (sif.rx_valid) begin
                    case (sif.rx_data)
                        8'h01: begin state_d = S_ADDR; cnt_d = '0; end
                        8'h02: begin
                            state_d = S_LEN;
                            is_wr_d = 1'b1;
`ifdef SPI_MEM_CHECKSUM_EN
                            csum_d  = '0;
`endif
                        end
                        8'h03: begin state_d = S_LEN; is_wr_d = 1'b0; end
                        8'h04: begin state_d = S_ACQ_WAIT; bus_req_d = 1'b1; cnt_d = '0; end
                        8'h05: bus_req_d = 1'b0;
                        8'h06: begin
                            tx_data_d = {4'b0, status_q};
                            tx_load_d = 1'b1;
                            status_d  = '0;
                        end
`ifdef SPI_MEM_CHECKSUM_EN
                        8'h07: begin tx_data_d = csum_q; tx_load_d = 1'b1; end
`endif
                        default: ;
                    endcase
                end
            end
            S_ADDR: begin
                if (sif.rx_valid) begin
                    addr_d = ADDR_W'({addr_q, sif.rx_data});
                    if (cnt_q == 16'(ADDR_BYTES - 1)) state_d = S_IDLE;
                    else                              cnt_d = cnt_q + 16'd1;
                end
            end
            S_LEN: begin
                if (sif.rx_valid) begin
                    len_d   = (sif.rx_data == 8'd0) ? 9'd256 : {1'b0, sif.rx_data};
                    disc_d  = ~owned;
                    if (!owned) status_d[0] = 1'b1;
                    state_d = is_wr_q ? S_WDATA : S_RDATA;
                end
            end
            S_WDATA, S_RDATA: begin
                if (!disc_q && !owned) begin
                    state_d     = S_IDLE;
                    status_d[3] = 1'b1;
                end else if (sif.rx_valid) begin
                    if (disc_q) begin
                        len_d = len_q - 9'd1;
                        if (len_q == 9'd1) state_d = S_IDLE;
                    end else if (state_q == S_WDATA) begin
                        wdata_d = sif.rx_data;
                        we_n_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = S_WSTROBE;
`ifdef SPI_MEM_CHECKSUM_EN
                        csum_d  = csum_q ^ sif.rx_data;
`endif
                    end else begin
                        oe_n_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = S_RACCESS;
                    end
                end
            end
            S_WSTROBE, S_RACCESS: begin
                if (!owned) begin
                    state_d     = S_IDLE;
                    we_n_d      = 1'b1;
                    oe_n_d      = 1'b1;
                    status_d[3] = 1'b1;
                end else if ((state_q == S_WSTROBE && cnt_q == 16'(WE_CYCLES - 1)) ||
                             (state_q == S_RACCESS && cnt_q == 16'(RD_CYCLES - 1))) begin
                    // Last strobe clock: close the access and step to the next byte.
                    we_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    addr_d  = addr_q + ADDR_W'(1);
                    len_d   = len_q - 9'd1;
                    if (state_q == S_RACCESS) begin
                        tx_data_d = sif.mem_rdata;
                        tx_load_d = 1'b1;
                    end
                    if (len_q == 9'd1)            state_d = S_IDLE;
                    else if (state_q == S_WSTROBE) state_d = S_WDATA;
                    else                           state_d = S_RDATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_ACQ_WAIT: begin
                if (sif.bus_gnt) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 16'(GNT_TIMEOUT - 1)) begin
                    bus_req_d   = 1'b0;
                    status_d[2] = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Bytes arriving while a strobe or acquire is in flight are lost.
        if (sif.rx_valid && (state_q == S_WSTROBE || state_q == S_RACCESS || state_q == S_ACQ_WAIT))
            status_d[1] = 1'b1;
    end
endmodule

// File: tb/tb_spi_mem_bridge.sv
// Randomized scoreboard bench for spi_mem_bridge against a command-level reference model.
module tb_spi_mem_bridge;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned WE_CYC  = 4;
    localparam int unsigned RD_CYC  = 2;
    localparam int unsigned GNT_TO  = 10;
    localparam int          GAP     = WE_CYC + 2;

    typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;

    logic clock_50 = 1'b0;
    logic reset    = 1'b0;
    always #5 clock_50 = ~clock_50;

    spi_mem_bridge_if #(.ADDR_W(ADDR_W)) sif();

    spi_mem_bridge #(.ADDR_W(ADDR_W), .WE_CYCLES(WE_CYC), .RD_CYCLES(RD_CYC), .GNT_TIMEOUT(GNT_TO)) dut (
        .clock_50 (clock_50),
        .reset    (reset),
        .sif      (sif)
    );

    logic [7:0] sram    [65536];
    logic [7:0] ref_mem [65536];
    assign sif.mem_rdata = sram[sif.mem_addr];

    int checks = 0;
    int errors = 0;
    wr_t        exp_wr[$];
    logic [7:0] exp_tx[$];
    int   tx_seen  = 0;
    int   wr_w     = 0;
    int   rd_w     = 0;
    logic trunc_ok = 1'b0;

    logic [15:0] m_addr   = '0;
    logic        m_req    = 1'b0;
    logic [3:0]  m_status = '0;
    logic [7:0]  m_csum   = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write-strobe monitor: checks address/data on each new pulse and its width.
    always @(negedge clock_50) begin
        if (reset && !sif.mem_we_n) begin
            if (wr_w == 0) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("write_addr", int'(sif.mem_addr), int'(e.a));
                    chk("write_data", int'(sif.mem_wdata), int'(e.d));
                end
                sram[sif.mem_addr] = sif.mem_wdata;
            end
            wr_w++;
        end else if (wr_w != 0) begin
            if (!trunc_ok) chk("we_width", wr_w, int'(WE_CYC));
            wr_w = 0;
        end
    end

    // Read-strobe width, strobe exclusivity and ownership monitor.
    always @(negedge clock_50) begin
        if (reset && !sif.mem_oe_n) rd_w++;
        else if (rd_w != 0) begin
            chk("oe_width", rd_w, int'(RD_CYC));
            rd_w = 0;
        end
        if (!sif.mem_we_n || !sif.mem_oe_n)
            chk("strobe_rule", int'((!sif.mem_we_n && !sif.mem_oe_n) || !(sif.bus_req && sif.bus_gnt)), 0);
    end

    // Transmit monitor.
    always @(negedge clock_50) begin
        if (sif.tx_load) begin
            tx_seen++;
            if (exp_tx.size() == 0) chk("unexpected_tx", int'(sif.tx_data), -1);
            else                    chk("tx_data", int'(sif.tx_data), int'(exp_tx.pop_front()));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock_50);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        sif.rx_valid = 1'b1;
        sif.rx_data  = b;
        tick(1);
        sif.rx_valid = 1'b0;
        tick(gap);
    endtask

    task automatic set_addr(input logic [15:0] a);
        send(8'h01, 0); send(a[15:8], 0); send(a[7:0], 1);
        m_addr = a;
    endtask

    task automatic acquire(input int d);
        send(8'h04, 0); tick(d);
        sif.bus_gnt = 1'b1;
        tick(2);
        m_req = 1'b1;
    endtask

    task automatic release_bus();
        send(8'h05, 2);
        m_req = 1'b0;
        sif.bus_gnt = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] data[$]);
        logic own;
        own = m_req && sif.bus_gnt;
        send(8'h02, 0); m_csum = '0;
        send(8'(data.size()), 0);
        if (!own) m_status[0] = 1'b1;
        foreach (data[i]) begin
            if (own) begin
                exp_wr.push_back('{a: m_addr, d: data[i]});
                ref_mem[m_addr] = data[i];
                m_csum ^= data[i];
                m_addr++;
            end
            send(data[i], GAP);
        end
    endtask

    task automatic do_read(input int n);
        logic own;
        own = m_req && sif.bus_gnt;
        send(8'h03, 0);
        send(8'(n), 0);
        if (!own) m_status[0] = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (own) begin
                exp_tx.push_back(ref_mem[m_addr]);
                m_addr++;
            end
            send(8'($urandom), GAP);
        end
    endtask

    task automatic do_status();
        exp_tx.push_back({4'b0, m_status});
        m_status = '0;
        send(8'h06, 2);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] q[$];
        int t0;
        sif.rx_valid = 1'b0;
        sif.rx_data  = '0;
        sif.bus_gnt  = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            sram[i]    = 8'($urandom);
            ref_mem[i] = sram[i];
        end
        tick(3);
        chk("rst_bus_req", int'(sif.bus_req), 0);
        chk("rst_we_n", int'(sif.mem_we_n), 1);
        chk("rst_oe_n", int'(sif.mem_oe_n), 1);
        chk("rst_busy", int'(sif.busy), 0);
        chk("rst_tx_data", int'(sif.tx_data), 0);
        chk("rst_tx_load", int'(sif.tx_load), 0);
        chk("rst_addr", int'(sif.mem_addr), 0);
        reset = 1'b1;
        tick(2);

        // Acquire with a late grant, then a 3-byte burst write.
        send(8'h04, 0); tick(3);
        chk("acq_req_held", int'(sif.bus_req), 1);
        chk("acq_busy", int'(sif.busy), 1);
        sif.bus_gnt = 1'b1; tick(2); m_req = 1'b1;
        chk("acq_done_busy", int'(sif.busy), 0);
        chk("acq_req_kept", int'(sif.bus_req), 1);
        set_addr(16'h1234);
        q = '{8'hAA, 8'hBB, 8'hCC}; do_write(q);
        chk("addr_after_write", int'(sif.mem_addr), int'(m_addr));
        set_addr(16'h1234);
        do_read(2);

        // Address wrap plus an overrun byte injected during the strobe.
        do_status();
        set_addr(16'hFFFF);
        send(8'h02, 0); send(8'h02, 0); m_csum = '0;
        exp_wr.push_back('{a: 16'hFFFF, d: 8'h11}); ref_mem[16'hFFFF] = 8'h11;
        send(8'h11, 1);
        send(8'h99, GAP); m_status[1] = 1'b1;
        exp_wr.push_back('{a: 16'h0000, d: 8'h22}); ref_mem[16'h0000] = 8'h22;
        send(8'h22, GAP);
        m_addr = 16'h0001;
        chk("addr_wrap", int'(sif.mem_addr), 1);
        do_status();

        // Grant never arrives: timeout after GNT_TO clocks.
        release_bus();
        send(8'h04, 0); tick(int'(GNT_TO) - 1);
        chk("timeout_req_high", int'(sif.bus_req), 1);
        tick(1);
        chk("timeout_req_low", int'(sif.bus_req), 0);
        m_status[2] = 1'b1;
        tick(2);
        do_status();
        do_status();

        // Checksum command.
        acquire(1);
        q = '{8'h0F, 8'hF0, 8'h55}; do_write(q);
        t0 = tx_seen;
`ifdef SPI_MEM_CHECKSUM_EN
        exp_tx.push_back(m_csum);
        send(8'h07, 3);
        chk("csum_tx_count", tx_seen - t0, 1);
`else
        send(8'h07, 3);
        chk("no_csum_tx", tx_seen - t0, 0);
`endif

        // Randomized command mix.
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 5))
                0: set_addr(($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom));
                1, 2: begin
                    q.delete();
                    for (int i = 0; i < int'($urandom_range(1, 6)); i++) q.push_back(8'($urandom));
                    do_write(q);
                end
                3: do_read(int'($urandom_range(1, 6)));
                4: do_status();
                default: if (m_req) release_bus(); else acquire(int'($urandom_range(0, 5)));
            endcase
        end
        if (!m_req) acquire(0);
        q.delete();
        for (int i = 0; i < 256; i++) q.push_back(8'($urandom));
        do_write(q);
        chk("addr_after_256", int'(sif.mem_addr), int'(m_addr));
        do_status();

        // Grant lost in the middle of a burst.
        set_addr(16'h4000);
        send(8'h02, 0); send(8'h04, 0); m_csum = '0;
        for (int i = 0; i < 3; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            exp_wr.push_back('{a: m_addr, d: b}); ref_mem[m_addr] = b;
            if (i < 2) begin
                m_addr++;
                send(b, GAP);
            end else begin
                trunc_ok = 1'b1;
                send(b, 1);
            end
        end
        sif.bus_gnt = 1'b0;
        @(negedge clock_50);
        chk("lost_we_n_immediate", int'(sif.mem_we_n), 1);
        tick(1);
        chk("lost_busy", int'(sif.busy), 0);
        trunc_ok = 1'b0;
        m_status[3] = 1'b1;
        do_status();

        // Reset in the middle of a write strobe.
        release_bus();
        acquire(0);
        send(8'h02, 0); send(8'h01, 0);
        exp_wr.push_back('{a: m_addr, d: 8'h5A});
        trunc_ok = 1'b1;
        send(8'h5A, 1);
        chk("strobe_before_reset", int'(sif.mem_we_n), 0);
        reset = 1'b0;
        #1;
        chk("async_we_n", int'(sif.mem_we_n), 1);
        chk("async_bus_req", int'(sif.bus_req), 0);
        tick(2);
        reset = 1'b1;
        sif.bus_gnt = 1'b0;
        tick(2);
        trunc_ok = 1'b0;
        chk("post_rst_busy", int'(sif.busy), 0);
        chk("post_rst_addr", int'(sif.mem_addr), 0);
        chk("post_rst_tx", int'(sif.tx_data), 0);
        m_status = '0;
        do_status();

        tick(4);
        chk("exp_wr_drained", exp_wr.size(), 0);
        chk("exp_tx_drained", exp_tx.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_mem_bridge.md
Name: spi_mem_bridge

Overview:
Parametrised successor to the single-byte SPI-to-SRAM command engine. It consumes the byte stream from the existing SPI byte slave and drives the shared SRAM bus. It adds:
- configurable address width
- length-prefixed burst read/write with auto-increment
- a bus request/grant handshake with timeout
- programmable strobe widths
- a sticky status register

It sits between SPI_slave and the SRAM/Coco bus mux.

Parameters:
ADDR_W, 16, memory address width (9..24); ADDR_BYTES = ceil(ADDR_W/8) address bytes sent MSB first.
WE_CYCLES, 4, clocks mem_we_n is held low per write byte (1..15).
RD_CYCLES, 2, clocks mem_oe_n is low before mem_rdata is sampled (1..15).
GNT_TIMEOUT, 255, clocks to wait for bus_gnt before abandoning acquire (1..65535).

Ports:
clock_50  in  1  system clock
reset  in  1  asynchronous active-low reset
rx_valid  in  1  one-clock pulse: rx_data holds a received SPI byte
rx_data  in  8  received byte
tx_load  out  1  one-clock pulse: tx_data is next byte to shift out
tx_data  out  8  byte to transmit
bus_req  out  1  request ownership of SRAM bus
bus_gnt  in  1  ownership granted (level)
mem_addr  out  ADDR_W  SRAM address, valid while bus_req & bus_gnt
mem_wdata  out  8  write data, driven while mem_we_n low
mem_rdata  in  8  SRAM read data
mem_we_n  out  1  SRAM write strobe, active low
mem_oe_n  out  1  SRAM output enable, active low
busy  out  1  FSM not in IDLE

Behaviour:
Reset values (async, reset low):
- FSM in IDLE; addr = 0; len = 0.
- bus_req = 0; tx_load = 0; tx_data = 0.
- mem_we_n = 1; mem_oe_n = 1; status = 0; busy = 0.

Commands, accepted in IDLE only:
- 0x01 SET_ADDR -> ADDR; collect ADDR_BYTES bytes, shift in MSB first, truncate to ADDR_W.
- 0x02 WRITE -> LEN -> WDATA.
- 0x03 READ -> LEN -> RDATA.
- 0x04 ACQUIRE -> ACQ_WAIT.
- 0x05 RELEASE -> bus_req = 0 the next clock.
- 0x06 STATUS -> tx_data = status, tx_load pulses the next clock; then clear status.
- Any other byte is ignored and the FSM stays in IDLE.

LEN byte: count N = byte, with 0 meaning 256.

WDATA:
- Each rx byte latches into mem_wdata; go to WSTROBE.
- WSTROBE holds mem_we_n = 0 for exactly WE_CYCLES clocks.
- Then mem_we_n = 1 for one clock, addr++, N--.
- Return to WDATA, or to IDLE when N reaches 0.

RDATA:
- Each rx byte (a dummy byte) starts RACCESS: mem_oe_n = 0 for RD_CYCLES clocks.
- Sample mem_rdata on the last of those clocks.
- The next clock: tx_data = sample, tx_load = 1, mem_oe_n = 1, addr++, N--.
- Return to RDATA, or to IDLE when N reaches 0.

ACQ_WAIT:
- bus_req = 1.
- On bus_gnt = 1, go to IDLE with owned = 1.
- After GNT_TIMEOUT clocks without grant: bus_req = 0, status[2] TIMEOUT = 1, go to IDLE.

Ownership:
- owned = bus_req & bus_gnt.
- If bus_gnt drops mid-burst: abort to IDLE, deassert strobes immediately, set status[3] LOST.

WRITE or READ without ownership:
- The LEN byte is still consumed, but data bytes are discarded with no strobes.
- Set status[0] NOBUS, then return to IDLE after N bytes.

Overrun: rx_valid arriving during WSTROBE, RACCESS or ACQ_WAIT drops the byte and sets status[1] OVR.

Address wrap: addr = 2^ADDR_W - 1, +1 -> 0.

Strobe rules:
- mem_we_n and mem_oe_n are never low simultaneously.
- Neither is low unless owned.

Status byte: {4'b0, LOST, TIMEOUT, OVR, NOBUS}, all flags sticky until a STATUS read.

Reset mid-operation: all strobes deassert asynchronously and bus_req drops.

Optional Feature:
SPI_MEM_CHECKSUM_EN
- Defined:
  - An 8-bit register csum XORs every byte actually written to SRAM.
  - csum is cleared by the WRITE command byte.
  - Command 0x07 loads tx_data = csum and pulses tx_load the next clock.
- Undefined: no csum register, and 0x07 is ignored like any unknown command.

Test Plan:
1. ADDR_W=16: 0x04 with bus_gnt raised after 3 clocks -> bus_req=1 held; then 01 12 34, 02 03 AA BB CC -> three mem_we_n low pulses of 4 clocks each at 0x1234/0x1235/0x1236 with data AA/BB/CC; addr ends 0x1237.
2. After test 1: 01 12 34, 03 02, two dummy bytes -> mem_oe_n pulses of 2 clocks; tx_load pulses carry AA then BB.
3. No grant, GNT_TIMEOUT=10: 0x04 -> bus_req drops after 10 clocks; 06 -> tx_data=0x04, then 06 -> 0x00.
4. Owned; 01 FF FF, 02 02 11 22 -> writes at 0xFFFF then 0x0000 (wrap); rx byte injected during WSTROBE -> dropped, status = 0x02.
5. Owned mid-burst of 02 04: drop bus_gnt after the 2nd byte -> strobes high the same clock, FSM IDLE, status = 0x08; assert reset during WSTROBE -> mem_we_n = 1 asynchronously.
6. With SPI_MEM_CHECKSUM_EN: 02 03 0F F0 55 then 07 -> tx_data = 0xAA; without the macro, 07 produces no tx_load.
